// File: rtl/cmul_driver_pkg.sv
// Shared definitions for the complex-multiplier driver: state encoding and
// default widths/timeouts.
package cmul_driver_pkg;

  localparam int unsigned DEF_W       = 8;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND_RE = 3'd1,
    S_SEND_IM = 3'd2,
    S_WAIT_RE = 3'd3,
    S_WAIT_IM = 3'd4,
    S_OUT     = 3'd5,
    S_ERR     = 3'd6
  } state_t;

endpackage

// File: rtl/cmul_driver_timeout_counter.sv
// Per-wait-state watchdog. Loaded on clear and counts down while enabled.
// o_expired flags the last cycle of the wait window.
module cmul_timeout_counter
  import cmul_driver_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= LOAD;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // A wait window lasts TIMEOUT cycles; a ready in the final cycle still wins.
  assign o_expired = (r_count == '0);

endmodule

// File: rtl/cmul_driver.sv
// Sequences one complex product through a shared scalar multiplier:
// sends the re and im operand pairs, then collects two result pulses.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | waiting for host operands, in_ready high
// S_SEND_RE | start pulse, X/Y = a_re/b_re
// S_SEND_IM | X/Y = a_im/b_im
// S_WAIT_RE | waiting for first ready, result -> out_re
// S_WAIT_IM | waiting for second ready, result -> out_im
// S_OUT     | product presented until host accepts
// S_ERR     | multiplier timed out, held until reset
module cmul_driver
  import cmul_driver_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned W       = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a_re,
  input  logic [W-1:0]   a_im,
  input  logic [W-1:0]   b_re,
  input  logic [W-1:0]   b_im,
  output logic           start,
  output logic [W-1:0]   X,
  output logic [W-1:0]   Y,
  input  logic [2*W-1:0] res,
  input  logic           ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_re,
  output logic [2*W-1:0] out_im,
  output logic           err
);

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_a_re, r_a_im, r_b_re, r_b_im;
  logic [2*W-1:0] r_out_re, r_out_im;
  logic           r_err;
  logic           w_clear, w_enable, w_expired;

  cmul_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    start     = 1'b0;
    X         = '0;
    Y         = '0;
    out_valid = 1'b0;
    w_clear   = 1'b1;
    w_enable  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_SEND_RE;
      end
      S_SEND_RE: begin
        start  = 1'b1;
        X      = r_a_re;
        Y      = r_b_re;
        w_next = S_SEND_IM;
      end
      S_SEND_IM: begin
        X      = r_a_im;
        Y      = r_b_im;
        w_next = S_WAIT_RE;
      end
      S_WAIT_RE: begin
        w_clear  = 1'b0;
        w_enable = 1'b1;
        if (ready) begin
          w_next  = S_WAIT_IM;
          w_clear = 1'b1;
        end else if (w_expired) begin
          w_next = S_ERR;
        end
      end
      S_WAIT_IM: begin
        w_clear  = 1'b0;
        w_enable = 1'b1;
        if (ready) w_next = S_OUT;
        else if (w_expired) w_next = S_ERR;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      S_ERR: begin
        w_next = S_ERR;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_re   <= '0;
      r_a_im   <= '0;
      r_b_re   <= '0;
      r_b_im   <= '0;
      r_out_re <= '0;
      r_out_im <= '0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && in_valid) begin
        r_a_re <= a_re;
        r_a_im <= a_im;
        r_b_re <= b_re;
        r_b_im <= b_im;
      end
      if ((r_state == S_WAIT_RE) && ready) r_out_re <= res;
      if ((r_state == S_WAIT_IM) && ready) r_out_im <= res;
      if (w_next == S_ERR) r_err <= 1'b1;
    end
  end

  assign out_re = r_out_re;
  assign out_im = r_out_im;
  assign err    = r_err;

endmodule

// File: tb/tb_cmul_driver.sv
// Bench for cmul_driver: a behavioural scalar-multiplier model, a host
// driver and a scoreboard holding complex products computed arithmetically.
module tb_cmul_driver;

  localparam int W  = 8;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic          start;
  logic [W-1:0]  X, Y;
  logic [15:0]   res;
  logic          ready;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_re, out_im;
  logic          err;

  cmul_driver #(.TIMEOUT(TO), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .start(start), .X(X), .Y(Y), .res(res), .ready(ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_starts = 0;
  int n_out    = 0;
  int xy_bad   = 0;
  int m_lat1   = 1;
  int m_gap    = 1;
  bit m_silent = 1'b0;
  int sink_mode = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Complex product of two signed W-bit operands, each part truncated to 2W bits.
  function automatic logic [31:0] cprod(input logic [7:0] ar, ai, br, bi);
    int re, im;
    re = $signed(ar) * $signed(br) - $signed(ai) * $signed(bi);
    im = $signed(ar) * $signed(bi) + $signed(ai) * $signed(br);
    return {re[15:0], im[15:0]};
  endfunction

  task automatic send(input logic [7:0] ar, ai, br, bi, input bit keep);
    int n = 0;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin step(); n++; end
    chk("accept", 32'(in_ready), 1);
    exp_q.push_back(cprod(ar, ai, br, bi));
    step();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    chk("drain", 32'(exp_q.size()), 0);
  endtask

  // Scalar multiplier model: takes the two operand pairs it is sent and
  // answers with the real then imaginary product after configured delays.
  initial begin : mult_model
    logic [7:0]  xr, yr, xi, yi;
    logic [31:0] p;
    ready = 1'b0;
    res   = '0;
    forever begin
      step();
      if (rst && start) begin
        xr = X; yr = Y;
        step();
        xi = X; yi = Y;
        p = cprod(xr, xi, yr, yi);
        if (!m_silent) begin
          repeat (m_lat1) step();
          ready = 1'b1; res = p[31:16];
          step();
          ready = 1'b0;
          repeat (m_gap - 1) step();
          ready = 1'b1; res = p[15:0];
          step();
          ready = 1'b0;
        end
      end
    end
  end

  initial begin : sink
    out_ready = 1'b0;
    forever begin
      step();
      case (sink_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : monitor
    logic        prev_start, prev_acc;
    logic [15:0] last_re, last_im;
    logic [31:0] e;
    prev_start = 1'b0;
    prev_acc   = 1'b0;
    last_re    = '0;
    last_im    = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_start = 1'b0;
        prev_acc   = 1'b0;
      end else begin
        if (prev_acc) begin
          chk("ov_drop", 32'(out_valid), 0);
          chk("hold_re", 32'(out_re), 32'(last_re));
          chk("hold_im", 32'(out_im), 32'(last_im));
        end
        if (start) n_starts++;
        if (!start && !prev_start && (X != 0 || Y != 0)) xy_bad++;
        prev_start = start;
        prev_acc   = out_valid && out_ready;
        if (prev_acc) begin
          last_re = out_re;
          last_im = out_im;
          n_out++;
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_re", 32'(out_re), 32'(e[31:16]));
            chk("out_im", 32'(out_im), 32'(e[15:0]));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, bad, s0, o0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_xy", {16'h0, X, Y}, 0);
    chk("rst_out", {out_re, out_im}, 0);
    step();
    rst = 1'b1;
    repeat (2) step();

    // Single product with backpressure
    m_lat1 = 4; m_gap = 10; sink_mode = 0;
    send(8'd3, 8'd4, 8'd5, 8'd6, 1'b0);
    chk("send_re_start", 32'(start), 1);
    chk("send_re_xy", {16'h0, X, Y}, 32'h0305);
    step();
    chk("send_im_start", 32'(start), 0);
    chk("send_im_xy", {16'h0, X, Y}, 32'h0406);
    n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    chk("ov_seen", 32'(out_valid), 1);
    in_valid = 1'b1; a_re = 8'd9; a_im = 8'd9; b_re = 8'd9; b_im = 8'd9;
    bad = 0;
    repeat (20) begin
      step();
      if (!out_valid || out_re != 16'hFFF7 || out_im != 16'h0026 || in_ready) bad++;
    end
    in_valid = 1'b0;
    chk("bp_stable", 32'(bad), 0);
    chk("single_re", 32'(out_re), 32'h0000FFF7);
    chk("single_im", 32'(out_im), 32'h00000026);
    chk("bp_starts", 32'(n_starts), 1);
    sink_mode = 1;
    wait_drain(20);
    chk("idle_after_out", 32'(in_ready), 1);

    // Randomised products with random latencies and random host backpressure
    sink_mode = 2;
    for (int i = 0; i < 10; i++) begin
      m_lat1 = $urandom_range(1, 30);
      m_gap  = $urandom_range(1, 30);
      send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      wait_drain(200);
    end
    chk("rand_err", 32'(err), 0);

    // Both ready pulses in the last cycle of their wait windows
    sink_mode = 1; m_lat1 = TO; m_gap = TO;
    o0 = n_out;
    send(8'h80, 8'h7F, 8'h81, 8'hFF, 1'b0);
    wait_drain(2 * TO + 50);
    chk("edge_err", 32'(err), 0);
    chk("edge_out", 32'(n_out - o0), 1);

    // Reset while waiting for the imaginary result, then a stray ready
    m_lat1 = 3; m_gap = 12;
    s0 = n_starts;
    send(8'd7, 8'd2, 8'd11, 8'd5, 1'b0);
    repeat (7) step();
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_re", 32'(out_re), 0);
    step();
    rst = 1'b1;
    exp_q.delete();
    bad = 0;
    repeat (15) begin
      step();
      if (out_valid || !in_ready) bad++;
    end
    chk("stray_idle", 32'(bad), 0);
    chk("stray_out", {out_re, out_im}, 0);
    chk("stray_starts", 32'(n_starts - s0), 1);

    // Three products with in_valid held high
    m_lat1 = 2; m_gap = 3;
    s0 = n_starts; o0 = n_out;
    send(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    send(8'hF0, 8'd9, 8'd100, 8'h85, 1'b1);
    send(8'd127, 8'h80, 8'h80, 8'd127, 1'b1);
    in_valid = 1'b0;
    wait_drain(200);
    chk("b2b_starts", 32'(n_starts - s0), 3);
    chk("b2b_outs", 32'(n_out - o0), 3);

    // Multiplier never answers
    m_silent = 1'b1;
    s0 = n_starts;
    send(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    exp_q.delete();
    repeat (TO + 1) step();
    chk("to_err_early", 32'(err), 0);
    step();
    chk("to_err", 32'(err), 1);
    in_valid = 1'b1;
    bad = 0;
    repeat (30) begin
      step();
      if (in_ready || out_valid || !err) bad++;
    end
    in_valid = 1'b0;
    chk("err_sticky", 32'(bad), 0);
    chk("err_starts", 32'(n_starts - s0), 1);
    rst = 1'b0;
    #1;
    chk("err_cleared", {30'h0, err, in_ready}, 32'h1);
    step();
    rst = 1'b1;
    step();

    chk("xy_zero", 32'(xy_bad), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cmul_driver.md
CMUL_DRIVER -- requirements
Module: cmul_driver

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles to wait for each multiplier ready pulse.
REQ-002 Parameter W, default 8, operand component width; result component width is 2*W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  host offers an operand pair.
REQ-006 in_ready  output  1  driver accepts the operand pair; high only in IDLE.
REQ-007 a_re, a_im, b_re, b_im  input  W each  operand components A=a_re+j*a_im and B=b_re+j*b_im.
REQ-008 start  output  1  one-cycle start pulse to the multiplier.
REQ-009 X, Y  output  W each  multiplier operand bus.
REQ-010 res  input  2W  multiplier result bus.
REQ-011 ready  input  1  multiplier result-valid pulse.
REQ-012 out_valid  output  1  product available to host.
REQ-013 out_ready  input  1  host accepts the product.
REQ-014 out_re, out_im  output  2W each  captured product components.
REQ-015 err  output  1  sticky timeout flag.

Function
REQ-016 States: IDLE, SEND_RE, SEND_IM, WAIT_RE, WAIT_IM, OUT, ERR.
REQ-017 IDLE: in_ready=1; when in_valid=1, register all four operands and go to SEND_RE.
REQ-018 SEND_RE (1 cycle): start=1, X=a_re, Y=b_re; then go to SEND_IM.
REQ-019 SEND_IM (1 cycle): start=0, X=a_im, Y=b_im; then go to WAIT_RE.
REQ-020 X and Y SHALL be 0 outside SEND_RE and SEND_IM.
REQ-021 WAIT_RE: on ready=1, capture res into out_re and go to WAIT_IM.
REQ-022 WAIT_IM: on ready=1, capture res into out_im and go to OUT.
REQ-023 A ready pulse that arrives in any state other than WAIT_RE or WAIT_IM is ignored.
REQ-024 Each WAIT state runs a cycle counter that is cleared on entry; if it reaches TIMEOUT with no ready, set err=1 and go to ERR.
REQ-025 If ready=1 in the same cycle the counter reaches TIMEOUT, the ready is honoured and no error is raised.
REQ-026 OUT: out_valid=1 and out_re/out_im are held stable; when out_ready=1, go to IDLE.
REQ-027 out_valid deasserts in the cycle after acceptance; out_re/out_im keep their last value until the next capture.
REQ-028 ERR: in_ready=0 and out_valid=0; the block stays in ERR until reset.
REQ-029 Minimum throughput: IDLE, SEND_RE, SEND_IM, then multiplier latency, then OUT, then IDLE (no back-to-back acceptance in OUT).
REQ-030 Results pass through unmodified, with no sign or width conversion.

Reset
REQ-031 With rst=0, asynchronously force: state=IDLE, counter=0, operand and result registers=0, start=0, X=Y=0, out_valid=0, err=0, in_ready=1.
REQ-032 A reset asserted mid-transaction aborts the transaction; the block ignores the multiplier's late ready pulses after reset because it is in IDLE.

Structure
REQ-033 A shared package holds the state enumeration, the default W and the default TIMEOUT.
REQ-034 One sub-module, cmul_timeout_counter (clear, enable, expired), is natural; all other logic lives inline.

Verification
REQ-035 Single product: A=3+j4, B=5+j6, model returns -9 then 38 with ready 10 cycles apart -> X/Y sequence 3/5 then 4/6, start for 1 cycle, out_re=0xFFF7, out_im=0x0026, out_valid held until out_ready.
REQ-036 Backpressure: hold out_ready=0 for 20 cycles -> out_valid stays 1, outputs stable, in_ready=0, and a new in_valid is not accepted.
REQ-037 Timeout: the model never asserts ready -> err=1 exactly TIMEOUT cycles after entering WAIT_RE; in_ready stays 0 until reset.
REQ-038 Boundary: ready arrives on cycle TIMEOUT in WAIT_IM -> no err, and out_im is captured.
REQ-039 Reset mid-WAIT_IM, followed by a stray ready -> state is IDLE, out_valid=0, nothing is captured.
REQ-040 Back-to-back: 3 products with in_valid held high -> 3 correct results in order, with exactly one start pulse per product.
